// File: rtl/kmeans_pkg.sv
// kmeans_pkg: constants and types shared by the kMeans host-side driver
// (kmeans_stream_tx, kmeans_lfsr16) and the kMeans clustering core.
//   CLUSTER_SIZE      : number of centroids sent and received per job
//   DATA_SIZE         : default number of points streamed per job
//   POINT_W           : point word width, {x[7:0], y[7:0]}
//   LFSR_DEFAULT_SEED : replaces an all-zero seed (zero would lock the LFSR)
//   LFSR_TAP_MASK     : feedback taps s[0], s[2], s[3], s[5]
package kmeans_pkg;

  localparam int CLUSTER_SIZE = 4;
  localparam int DATA_SIZE    = 4096;
  localparam int POINT_W      = 16;

  localparam logic [POINT_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam logic [POINT_W-1:0] LFSR_TAP_MASK     = 16'h002D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_INIT,
    ST_SEND_DATA,
    ST_WAIT_RESULT
  } kmeans_state_e;

endpackage

// File: rtl/kmeans_lfsr16.sv
// kmeans_lfsr16: 16-bit Fibonacci LFSR, right shift, used as the point
// generator for the kMeans driver.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load seed into the register (takes priority over en)
//   seed       : value loaded on load
//   en         : advance one step
//   state      : current LFSR value
module kmeans_lfsr16
  import kmeans_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [POINT_W-1:0] seed,
  input  logic               en,
  output logic [POINT_W-1:0] state
);

  logic fb;

  // Feedback is the XOR of the tapped bits; it enters at the MSB.
  assign fb = ^(state & LFSR_TAP_MASK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      state <= seed;
    end else if (en) begin
      state <= {fb, state[POINT_W-1:1]};
    end
  end

endmodule

// File: rtl/kmeans_stream_tx.sv
// kmeans_stream_tx: host-side driver for the kMeans core. On start it
// streams the 4 initial centroids followed by DATA_SIZE LFSR points as one
// contiguous in_valid burst, then collects 4 result centroids and reports
// done, or timeout if they do not all arrive within TIMEOUT_CYCLES.
//   clk, rst_n : clock, synchronous active-low reset (shared with the core)
//   start      : single-cycle job request, ignored while busy
//   seed       : LFSR seed (0 -> LFSR_DEFAULT_SEED), latched on start
//   init_pts   : initial centroids, word k = init_pts[16k+15:16k]
//   tx_valid   : core in_valid
//   tx_data    : core in_data, forced to 0 whenever tx_valid is low
//   rx_valid   : core out_valid
//   rx_data    : core out_data
//   busy       : job in progress
//   done       : one-cycle pulse, 4th result word captured
//   timeout    : one-cycle pulse, result wait expired
//   result     : captured centroids, word k = result[16k+15:16k]
module kmeans_stream_tx #(
  parameter int DATA_SIZE      = kmeans_pkg::DATA_SIZE,
  parameter int TIMEOUT_CYCLES = 1 << 24
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              start,
  input  logic [kmeans_pkg::POINT_W-1:0]                    seed,
  input  logic [kmeans_pkg::CLUSTER_SIZE*kmeans_pkg::POINT_W-1:0] init_pts,
  output logic                                              tx_valid,
  output logic [kmeans_pkg::POINT_W-1:0]                    tx_data,
  input  logic                                              rx_valid,
  input  logic [kmeans_pkg::POINT_W-1:0]                    rx_data,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              timeout,
  output logic [kmeans_pkg::CLUSTER_SIZE*kmeans_pkg::POINT_W-1:0] result
);

  import kmeans_pkg::*;

  localparam int PT_W = $clog2(DATA_SIZE);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PT_W-1:0] PT_LAST = PT_W'(DATA_SIZE - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES);

  typedef logic [CLUSTER_SIZE-1:0][POINT_W-1:0] word_arr_t;

  function automatic logic [POINT_W-1:0] eff_seed(input logic [POINT_W-1:0] s);
    return (s == '0) ? LFSR_DEFAULT_SEED : s;
  endfunction

  kmeans_state_e      state_q, state_d;
  logic [1:0]         init_cnt_q, init_cnt_d;
  logic [PT_W-1:0]    pt_cnt_q, pt_cnt_d;
  logic [1:0]         rx_cnt_q, rx_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               tx_valid_d;
  logic [POINT_W-1:0] tx_data_d;
  logic               busy_d, done_d, timeout_d;
  word_arr_t          result_q, result_d;
  word_arr_t          init_q;
  logic               init_latch;
  logic               lfsr_load, lfsr_en;
  logic [POINT_W-1:0] lfsr_state;

  kmeans_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (eff_seed(seed)),
    .en    (lfsr_en),
    .state (lfsr_state)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    pt_cnt_d   = pt_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    to_cnt_d   = to_cnt_q;
    tx_valid_d = 1'b0;
    tx_data_d  = '0;
    busy_d     = busy;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    result_d   = result_q;
    init_latch = 1'b0;
    lfsr_load  = 1'b0;
    lfsr_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Word 0 comes straight from the port so the burst starts on the
          // cycle right after start; words 1..3 come from the latched copy.
          state_d    = ST_SEND_INIT;
          init_latch = 1'b1;
          lfsr_load  = 1'b1;
          result_d   = '0;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = init_pts[POINT_W-1:0];
          init_cnt_d = '0;
        end
      end

      ST_SEND_INIT: begin
        // init_cnt_q is the index of the word currently on tx_data.
        tx_valid_d = 1'b1;
        if (init_cnt_q == 2'd3) begin
          state_d   = ST_SEND_DATA;
          tx_data_d = lfsr_state;
          lfsr_en   = 1'b1;
          pt_cnt_d  = '0;
        end else begin
          tx_data_d  = init_q[init_cnt_q + 2'd1];
          init_cnt_d = init_cnt_q + 2'd1;
        end
      end

      ST_SEND_DATA: begin
        // pt_cnt_q is the index of the point currently on tx_data; the LFSR
        // is always one step ahead of what is being presented.
        if (pt_cnt_q == PT_LAST) begin
          state_d  = ST_WAIT_RESULT;
          to_cnt_d = '0;
          rx_cnt_d = '0;
        end else begin
          tx_valid_d = 1'b1;
          tx_data_d  = lfsr_state;
          lfsr_en    = 1'b1;
          pt_cnt_d   = pt_cnt_q + PT_W'(1);
        end
      end

      ST_WAIT_RESULT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (rx_valid) begin
          result_d[rx_cnt_q] = rx_data;
          rx_cnt_d           = rx_cnt_q + 2'd1;
        end
        // A 4th word arriving on the expiry cycle completes the job.
        if (rx_valid && (rx_cnt_q == 2'd3)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      init_cnt_q <= '0;
      pt_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      to_cnt_q   <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      pt_cnt_q   <= pt_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      to_cnt_q   <= to_cnt_d;
      tx_valid   <= tx_valid_d;
      tx_data    <= tx_data_d;
      busy       <= busy_d;
      done       <= done_d;
      timeout    <= timeout_d;
      result_q   <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    if (init_latch) begin
      init_q <= init_pts;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_kmeans_stream_tx.sv
module tb_kmeans_stream_tx;

  localparam int DSZ   = 16;
  localparam int TMO   = 32;
  localparam int BURST = 4 + DSZ;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed = '0;
  logic [63:0] init_pts = '0;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_data = '0;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        busy, done, timeout;
  logic [63:0] result;

  kmeans_stream_tx #(.DATA_SIZE(DSZ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .seed     (seed),
    .init_pts (init_pts),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .result   (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [63:0] res;
  } evt_t;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_tx[$];
  evt_t        exp_evt[$];
  bit          mon_en = 1'b0;
  bit          abort = 1'b0;
  int          run_len = 0;
  int          wait_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] mon_word;
  evt_t        mon_evt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference point sequence: Fibonacci LFSR, taps 0,2,3,5, shifting right.
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_evt(input bit d, input logic [63:0] r);
    evt_t e;
    e.is_done = d;
    e.res     = r;
    exp_evt.push_back(e);
  endtask

  task automatic start_job(input logic [15:0] s, input logic [63:0] ip);
    logic [15:0] p;
    for (int k = 0; k < 4; k++) exp_tx.push_back(ip[16*k +: 16]);
    p = (s == 16'h0) ? 16'hACE1 : s;
    for (int k = 0; k < DSZ; k++) begin
      exp_tx.push_back(p);
      p = ref_next(p);
    end
    seed = s;
    init_pts = ip;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_latency_valid", 64'(tx_valid), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_burst_end();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (exp_tx.size() == 0 && !tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("burst_end_bound", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("idle_bound", 64'(ok), 64'd1);
    check("events_consumed", 64'(exp_evt.size()), 64'd0);
  endtask

  task automatic send_word(input logic [15:0] w);
    rx_valid = 1'b1;
    rx_data  = w;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_until_expiry_edge();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (wait_cnt == TMO) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("expiry_align_bound", 64'(ok), 64'd1);
  endtask

  // Monitor: pops expected tx words and end-of-job events as the DUT shows them.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_valid) begin
        run_len++;
        if (exp_tx.size() == 0) begin
          check("tx_extra_word", 64'(tx_valid), 64'd0);
        end else begin
          mon_word = exp_tx.pop_front();
          check("tx_data", 64'(tx_data), 64'(mon_word));
        end
      end else begin
        check("tx_idle_zero", 64'(tx_data), 64'd0);
        if (prev_valid) begin
          if (!abort) check("burst_len", 64'(run_len), 64'(BURST));
          run_len  = 0;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      if (done || timeout) begin
        if (exp_evt.size() == 0) begin
          check("evt_unexpected", 64'({done, timeout}), 64'd0);
        end else begin
          mon_evt = exp_evt.pop_front();
          check("evt_done", 64'(done), 64'(mon_evt.is_done));
          check("evt_timeout", 64'(timeout), 64'(!mon_evt.is_done));
          check("evt_result", result, mon_evt.res);
          check("evt_busy_low", 64'(busy), 64'd0);
          if (!mon_evt.is_done) check("timeout_latency", 64'(wait_cnt), 64'(TMO + 1));
        end
      end
      prev_valid = tx_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ip;
    logic [63:0] w;
    logic [15:0] s;
    int gap;

    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_result", result, 64'd0);

    // Idle with stray rx_valid pulses: must be ignored.
    for (int i = 0; i < 10; i++) begin
      rx_valid = i[0];
      rx_data  = 16'(16'h5A5A + i);
      tick();
    end
    rx_valid = 1'b0;
    check("idle_result", result, 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_tx_valid", 64'(tx_valid), 64'd0);

    // Directed job: known seed/centroids, results with a 2-cycle gap.
    start_job(16'hACE1, 64'h4040_C040_40C0_C0C0);
    wait_burst_end();
    push_evt(1'b1, 64'h4444_3333_2222_1111);
    send_word(16'h1111);
    send_word(16'h2222);
    tick();
    tick();
    send_word(16'h3333);
    send_word(16'h4444);
    wait_idle();

    // Seed 0, a second start and an rx pulse mid-burst (both ignored), then timeout.
    ip = {$urandom, $urandom};
    start_job(16'h0000, ip);
    repeat (6) tick();
    seed = 16'h1234;
    start = 1'b1;
    rx_valid = 1'b1;
    rx_data = 16'hBEEF;
    tick();
    start = 1'b0;
    rx_valid = 1'b0;
    wait_burst_end();
    push_evt(1'b0, 64'h0000_0000_2222_1111);
    send_word(16'h1111);
    send_word(16'h2222);
    wait_idle();
    check("timeout_result_kept", result, 64'h0000_0000_2222_1111);

    // 4th word on the expiry cycle: done wins.
    s = 16'($urandom);
    ip = {$urandom, $urandom};
    w = {$urandom, $urandom};
    start_job(s, ip);
    wait_burst_end();
    push_evt(1'b1, w);
    for (int k = 0; k < 3; k++) send_word(w[16*k +: 16]);
    wait_until_expiry_edge();
    send_word(w[63:48]);
    wait_idle();

    // 2nd word on the expiry cycle: captured, then timeout.
    s = 16'($urandom);
    ip = {$urandom, $urandom};
    w = {32'h0, 32'($urandom)};
    start_job(s, ip);
    wait_burst_end();
    push_evt(1'b0, w);
    send_word(w[15:0]);
    wait_until_expiry_edge();
    send_word(w[31:16]);
    wait_idle();

    // Reset pulse in the middle of the point stream.
    start_job(16'h1357, {$urandom, $urandom});
    repeat (8) tick();
    abort = 1'b1;
    rst_n = 1'b0;
    tick();
    check("midrst_tx_valid", 64'(tx_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_result", result, 64'd0);
    rst_n = 1'b1;
    exp_tx.delete();
    abort = 1'b0;
    tick();
    start_job(16'h2468, {$urandom, $urandom});
    wait_burst_end();
    w = {$urandom, $urandom};
    push_evt(1'b1, w);
    for (int k = 0; k < 4; k++) send_word(w[16*k +: 16]);
    wait_idle();

    // Randomized back-to-back jobs with random result gaps.
    for (int j = 0; j < 4; j++) begin
      s = 16'($urandom);
      ip = {$urandom, $urandom};
      start_job(s, ip);
      wait_burst_end();
      w = {$urandom, $urandom};
      push_evt(1'b1, w);
      for (int k = 0; k < 4; k++) begin
        send_word(w[16*k +: 16]);
        if (k < 3) begin
          gap = $urandom_range(0, 3);
          repeat (gap) tick();
        end
      end
      wait_idle();
    end

    repeat (3) tick();
    check("final_tx_queue_empty", 64'(exp_tx.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
